uart_rx_framed: RTL and testbench
=================================

Name: uart_rx_framed

Overview:
- UART receiver that consumes the serial line produced by the team's UART transmitter (8 data bits LSB-first, 1 start bit, 1 stop bit, no parity).
- Synchronises the asynchronous line into the clock domain, qualifies the start bit at mid-bit, and samples every bit at its centre.
- Presents each received byte with a one-cycle valid strobe, or a one-cycle framing-error strobe.
- Sits at the board RX pin, or on the TX serial output in loopback.

Parameters:
- CLKS_PER_BIT, 217, clock cycles per bit (i_Clock frequency / baud); legal values are 4 or more.

Ports:
- i_Clock  input  1  system clock
- i_Rst_L  input  1  reset, asynchronous, active-low
- i_RX_Serial  input  1  asynchronous serial line; idles high
- o_RX_DV  output  1  one-cycle strobe: o_RX_Byte is valid and newly updated
- o_RX_Byte  output  8  last correctly framed byte; held between frames
- o_RX_Frame_Err  output  1  one-cycle strobe: stop bit sampled low
- o_RX_Active  output  1  high from start-bit qualification to the end of the stop-bit sample

Behaviour:
- Clocking and reset: one clock (i_Clock). Reset is asynchronous and active-low (i_Rst_L).
- Reset values:
  - o_RX_DV=0, o_RX_Frame_Err=0, o_RX_Active=0, o_RX_Byte=8'h00.
  - Both synchroniser flops =1.
  - State=IDLE; bit counter=0; bit index=0.
- Reset mid-frame aborts the frame with no strobe.
- Synchroniser:
  - 2-flop chain; r_RX is the output of the second flop.
  - All decisions use r_RX only, so there is 2 cycles of input latency.
- Clock counter: width $clog2(CLKS_PER_BIT); cleared on every state change.
- Bit index: 3 bits.
- Let HALF = (CLKS_PER_BIT-1)/2, integer division.
- IDLE:
  - Counter=0, index=0.
  - If r_RX==0, go to START.
- START:
  - Count up to HALF.
  - When count==HALF: if r_RX==0, set o_RX_Active=1 and go to DATA. Otherwise (glitch) go to IDLE with no strobe.
- DATA:
  - Count up to CLKS_PER_BIT-1.
  - On that cycle, shift r_RX into the shift register at bit[index].
  - If index<7, increment index; else set index=0 and go to STOP.
- STOP:
  - Count up to CLKS_PER_BIT-1, then sample r_RX.
  - If r_RX==1: o_RX_Byte<=shift register and o_RX_DV=1 for exactly one cycle.
  - If r_RX==0: o_RX_Frame_Err=1 for one cycle and o_RX_Byte is unchanged.
  - In both cases o_RX_Active<=0 and go to CLEANUP.
- CLEANUP:
  - Wait until r_RX==1 (covers a break or a held-low line), then go to IDLE.
  - A valid frame spends 1 cycle here.
- Latency: o_RX_DV rises 2 + (HALF+1) + 9*CLKS_PER_BIT cycles (±1) after the i_RX_Serial falling edge of the start bit. This is the centre of the stop bit.
- Back-to-back frames: the next start edge may arrive as early as half a bit after the stop-bit sample; it must be detected with no lost frame.
- No flow control: a byte not taken on the o_RX_DV cycle is overwritten by the next valid frame.
- o_RX_DV and o_RX_Frame_Err are never high together.
- An undefined state encoding returns to IDLE.

Decomposition:
- Shared package uart_pkg holds:
  - State encodings (IDLE, START, DATA, STOP, CLEANUP; 3 bits wide).
  - Frame constants: DATA_BITS=8, START_LEVEL=0, STOP_LEVEL=1.
  - The TX block uses the same package.
- One sub-module, uart_rx_sync: 2-flop synchroniser, reset value 1, parameterised width, default 1.

Test Plan:
- All tests run with CLKS_PER_BIT=16.
1. Drive a correct frame of 8'h37 → exactly one o_RX_DV pulse, o_RX_Byte=8'h37, o_RX_Frame_Err stays 0, DV at 2+8+144 cycles (±1) after the start edge.
2. Loop the TX output into i_RX_Serial and send 8'h00, 8'hFF, 8'hA5 back-to-back → three DV pulses in that order with matching bytes, no errors.
3. Drive i_RX_Serial low for 5 cycles, then high → no DV, no error; o_RX_Active never rises; FSM back in IDLE.
4. After 8'h37, send 8'h5A with a low stop bit, hold low for 3 bit times, then release → one o_RX_Frame_Err pulse, no DV, o_RX_Byte stays 8'h37. A following 8'h81 frame then gives DV with byte 8'h81.
5. Assert i_Rst_L low during data bit 3 of a frame → all outputs reset to 0 immediately, no strobe. After release, a clean 8'hC3 frame is received correctly.
6. Skew the bit period by ±3% on 8'h55 → byte received correctly, no framing error.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and frame constants.
// The transmitter and receiver both import this package.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } uart_state_t;

  localparam int   DATA_BITS   = 8;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  // Counter value at which the start bit is re-checked (mid-bit).
  function automatic int half_count(input int clks_per_bit);
    return (clks_per_bit - 1) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for asynchronous inputs. Resets to all-ones so an
// idle-high serial line does not look like a start bit while in reset.
module uart_rx_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_p0 <= '1;
      q       <= '1;
    end else begin
      meta_p0 <= d;
      q       <= meta_p0;
    end
  end

endmodule

// File: rtl/uart_rx_framed.sv
// UART receiver, 8N1, LSB first. Start bit qualified at mid-bit, every later
// bit sampled one bit period apart; strobes either a good byte or a framing error.
module uart_rx_framed
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       i_Clock,
  input  logic       i_Rst_L,
  input  logic       i_RX_Serial,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_RX_Frame_Err,
  output logic       o_RX_Active
);

  localparam int             CW     = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  HALF_C = CW'(half_count(CLKS_PER_BIT));
  localparam logic [CW-1:0]  LAST_C = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]     LAST_IDX = 3'(DATA_BITS - 1);

  logic          rx_sync;
  uart_state_t   state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;

  uart_rx_sync #(
    .WIDTH (1)
  ) u_sync (
    .clk   (i_Clock),
    .rst_n (i_Rst_L),
    .d     (i_RX_Serial),
    .q     (rx_sync)
  );

  // Data shift register carries no reset; it is only observed after a full frame.
  always_ff @(posedge i_Clock) begin
    if (state == DATA && cnt == LAST_C) begin
      shreg[idx] <= rx_sync;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state          <= IDLE;
      cnt            <= '0;
      idx            <= '0;
      o_RX_DV        <= 1'b0;
      o_RX_Frame_Err <= 1'b0;
      o_RX_Active    <= 1'b0;
      o_RX_Byte      <= 8'h00;
    end else begin
      o_RX_DV        <= 1'b0;
      o_RX_Frame_Err <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          idx <= '0;
          if (rx_sync == START_LEVEL) begin
            state <= START;
          end
        end
        START: begin
          if (cnt == HALF_C) begin
            cnt <= '0;
            if (rx_sync == START_LEVEL) begin
              o_RX_Active <= 1'b1;
              state       <= DATA;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == LAST_C) begin
            cnt <= '0;
            if (idx != LAST_IDX) begin
              idx <= idx + 3'd1;
            end else begin
              idx   <= '0;
              state <= STOP;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (cnt == LAST_C) begin
            cnt <= '0;
            if (rx_sync == STOP_LEVEL) begin
              o_RX_Byte <= shreg;
              o_RX_DV   <= 1'b1;
            end else begin
              o_RX_Frame_Err <= 1'b1;
            end
            o_RX_Active <= 1'b0;
            state       <= CLEANUP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        CLEANUP: begin
          // A break or stuck-low line parks here until the line idles again.
          cnt <= '0;
          if (rx_sync == STOP_LEVEL) begin
            state <= IDLE;
          end
        end
        default: begin
          cnt   <= '0;
          idx   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_framed.sv
// Randomised bench for uart_rx_framed: a serial-line driver plays the transmitter,
// and a queue of expected frame outcomes is compared against DUT strobes every cycle.
`timescale 1ns/1ps
module tb_uart_rx_framed;

  localparam int CPB     = 16;
  localparam int BIT_NS  = CPB * 10;
  localparam int LAT_NOM = 2 + ((CPB - 1) / 2 + 1) + 9 * CPB;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    longint     start_cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       dv;
  logic [7:0] rx_byte;
  logic       ferr;
  logic       active;

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  exp_t   exp_q[$];
  logic [7:0] model_byte = 8'h00;
  int     dv_count = 0;
  int     ferr_count = 0;
  bit     glitch_watch = 1'b0;

  uart_rx_framed #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .i_Clock        (clk),
    .i_Rst_L        (rst_n),
    .i_RX_Serial    (rx),
    .o_RX_DV        (dv),
    .o_RX_Byte      (rx_byte),
    .o_RX_Frame_Err (ferr),
    .o_RX_Active    (active)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Compare process: every strobe must match the next expected frame outcome.
  always @(negedge clk) begin
    exp_t   e;
    longint lat;
    if (!rst_n) begin
      model_byte = 8'h00;
      exp_q.delete();
    end else begin
      chk("dv_ferr_exclusive", {31'd0, dv & ferr}, 32'd0);
      if (dv || ferr) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", {30'd0, dv, ferr}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("strobe_kind", {30'd0, dv, ferr}, e.is_err ? 32'd1 : 32'd2);
          if (!e.is_err) model_byte = e.data;
          lat = cyc - e.start_cyc;
          chk("strobe_latency", (lat >= LAT_NOM - 1 && lat <= LAT_NOM + 1) ? LAT_NOM : 32'(lat), LAT_NOM);
          chk("active_at_strobe", {31'd0, active}, 32'd0);
        end
        if (dv) dv_count++;
        if (ferr) ferr_count++;
      end
      chk("byte_hold", {24'd0, rx_byte}, {24'd0, model_byte});
      if (glitch_watch) chk("active_on_glitch", {31'd0, active}, 32'd0);
    end
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drives one 8N1 frame; a low stop bit is held low for hold_bits extra bit times.
  task automatic send_frame(input logic [7:0] data, input bit stop_ok, input int bit_ns, input int hold_bits);
    exp_t e;
    @(negedge clk);
    #2;
    e.is_err = !stop_ok;
    e.data = data;
    e.start_cyc = cyc;
    exp_q.push_back(e);
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      #(bit_ns);
      if (i == 3) chk("active_mid_frame", {31'd0, active}, 32'd1);
    end
    rx = stop_ok;
    #(bit_ns);
    if (!stop_ok) begin
      #(hold_bits * bit_ns);
      rx = 1'b1;
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    chk(name, exp_q.size(), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int         d0, f0, bt, gap, hold;
    logic [7:0] rb, abort_byte;
    bit         sok;

    rst_n = 1'b1;
    rx    = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_dv", {31'd0, dv}, 32'd0);
    chk("reset_ferr", {31'd0, ferr}, 32'd0);
    chk("reset_active", {31'd0, active}, 32'd0);
    chk("reset_byte", {24'd0, rx_byte}, 32'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(20);

    // Single clean frame.
    d0 = dv_count; f0 = ferr_count;
    send_frame(8'h37, 1'b1, BIT_NS, 0);
    drain("t1_drain");
    idle(5);
    chk("t1_dv_count", dv_count - d0, 32'd1);
    chk("t1_ferr_count", ferr_count - f0, 32'd0);
    chk("t1_byte", {24'd0, rx_byte}, 32'h37);

    // Back-to-back frames.
    d0 = dv_count; f0 = ferr_count;
    send_frame(8'h00, 1'b1, BIT_NS, 0);
    send_frame(8'hFF, 1'b1, BIT_NS, 0);
    send_frame(8'hA5, 1'b1, BIT_NS, 0);
    drain("t2_drain");
    idle(5);
    chk("t2_dv_count", dv_count - d0, 32'd3);
    chk("t2_ferr_count", ferr_count - f0, 32'd0);
    chk("t2_byte", {24'd0, rx_byte}, 32'hA5);

    // Short glitch must be rejected.
    d0 = dv_count; f0 = ferr_count;
    glitch_watch = 1'b1;
    @(negedge clk);
    #2 rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    idle(40);
    glitch_watch = 1'b0;
    chk("t3_dv_count", dv_count - d0, 32'd0);
    chk("t3_ferr_count", ferr_count - f0, 32'd0);

    // Framing error keeps the previous byte, then recovery.
    send_frame(8'h37, 1'b1, BIT_NS, 0);
    drain("t4_drain_a");
    d0 = dv_count; f0 = ferr_count;
    send_frame(8'h5A, 1'b0, BIT_NS, 3);
    idle(20);
    drain("t4_drain_b");
    chk("t4_ferr_count", ferr_count - f0, 32'd1);
    chk("t4_dv_count", dv_count - d0, 32'd0);
    chk("t4_byte_kept", {24'd0, rx_byte}, 32'h37);
    send_frame(8'h81, 1'b1, BIT_NS, 0);
    drain("t4_drain_c");
    idle(5);
    chk("t4_byte_next", {24'd0, rx_byte}, 32'h81);

    // Reset in the middle of data bit 3.
    d0 = dv_count; f0 = ferr_count;
    abort_byte = 8'h6B;
    @(negedge clk);
    #2 rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 3; i++) begin
      rx = abort_byte[i];
      #(BIT_NS);
    end
    rx = abort_byte[3];
    #(BIT_NS / 2);
    chk("t5_active_before_reset", {31'd0, active}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_reset_dv", {31'd0, dv}, 32'd0);
    chk("t5_reset_ferr", {31'd0, ferr}, 32'd0);
    chk("t5_reset_active", {31'd0, active}, 32'd0);
    chk("t5_reset_byte", {24'd0, rx_byte}, 32'h00);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(40);
    chk("t5_no_strobe", (dv_count - d0) + (ferr_count - f0), 32'd0);
    send_frame(8'hC3, 1'b1, BIT_NS, 0);
    drain("t5_drain");
    idle(5);
    chk("t5_byte", {24'd0, rx_byte}, 32'hC3);

    // Bit period skewed by about +/-3%.
    d0 = dv_count; f0 = ferr_count;
    send_frame(8'h55, 1'b1, BIT_NS - 5, 0);
    idle(10);
    drain("t6_drain_fast");
    chk("t6_byte_fast", {24'd0, rx_byte}, 32'h55);
    send_frame(8'h55, 1'b1, BIT_NS + 5, 0);
    idle(10);
    drain("t6_drain_slow");
    chk("t6_byte_slow", {24'd0, rx_byte}, 32'h55);
    chk("t6_ferr_count", ferr_count - f0, 32'd0);
    chk("t6_dv_count", dv_count - d0, 32'd2);

    // Random frames: mixed bytes, skew, gaps and occasional bad stop bits.
    for (int n = 0; n < 20; n++) begin
      rb   = 8'($urandom);
      sok  = ($urandom_range(0, 5) != 0);
      bt   = BIT_NS;
      if (sok) begin
        case ($urandom_range(0, 2))
          0: bt = BIT_NS - 5;
          1: bt = BIT_NS + 5;
          default: bt = BIT_NS;
        endcase
      end
      hold = sok ? 0 : $urandom_range(0, 2);
      send_frame(rb, sok, bt, hold);
      gap = (!sok || bt != BIT_NS) ? 10 + $urandom_range(0, 20) : $urandom_range(0, 1) * $urandom_range(0, 30);
      if (gap > 0) idle(gap);
    end
    drain("rand_drain");
    idle(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
